player_jump_ctrl: RTL and testbench
===================================

Name: player_jump_ctrl

Overview:
Player vertical-motion controller for the falling-floor game. It consumes the four floor positions and enables from the floor generator and produces the `time_gap` counter and `hit_ceiling` flag that drive floor scrolling. It owns the player's y coordinate, the jump/fall state machine, floor landing detection and death detection. It sits between the input/button logic and the floor generator, and feeds the VGA renderer.

Parameters:
PLAYER_SIZE, 20, player square edge in pixels
FLOOR_HALF_W, 50, floor spans [x-FLOOR_HALF_W, x+FLOOR_HALF_W]
CEIL_Y, 40, player_y at or above which upward motion converts to floor scroll
START_Y, 310, reset player_y (floor 0 top 330 minus PLAYER_SIZE)
BOTTOM_Y, 479, last visible row; player bottom beyond this is death
APEX_GAP, 320, time_gap value at which rising ends

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
tick  in  1  one-cycle game-step enable; all state updates only when tick=1
jump_btn  in  1  level jump request
player_x  in  10  player left column
floor_pos_x0..x3  in  10 each  floor centre columns
floor_pos_y0..y3  in  10 each  floor top rows
enable  in  4  per-floor valid
player_y  out  10  player top row
time_gap  out  9  ticks since current rise/fall began
hit_ceiling  out  1  floors must scroll down this tick
on_floor  out  1  state==GROUND
dead  out  1  state==DEAD
floor_idx  out  2  index of floor currently stood on

Behaviour:
- Clocking: clk only, with rst synchronous and active-high. Reset wins over tick.
- Reset values: state GROUND, player_y=START_Y, time_gap=0, floor_idx=0, hit_ceiling=0, on_floor=1, dead=0.
- Floor i is supporting when all hold: enable[i]=1; player_x+PLAYER_SIZE-1 >= x_i-FLOOR_HALF_W; player_x <= x_i+FLOOR_HALF_W; player_y+PLAYER_SIZE == y_i.
- Compute all sums 11-bit; treat x_i<FLOOR_HALF_W as left edge 0.
- When several floors qualify, the lowest index wins.
- States: GROUND, RISE, FALL, DEAD. Nothing changes when tick=0.
- GROUND:
  - time_gap=0; player_y tracks floor_pos_y[floor_idx]-PLAYER_SIZE.
  - jump_btn=1 → RISE, time_gap=1, no move this tick.
  - Otherwise, floor_idx no longer supporting (x overlap lost or enable low) → FALL, time_gap=1.
- RISE:
  - Move up 1 pixel when due, using the current time_gap value:
    - 1-79: every tick
    - 80-159: when time_gap[0]==0
    - 160-239: when time_gap[1:0]==0
    - 240-319: when time_gap[2:0]==0
  - A due move with player_y <= CEIL_Y holds player_y instead.
  - After the move, time_gap increments.
  - time_gap >= APEX_GAP at the start of a tick → FALL, time_gap=1, no move.
- hit_ceiling (combinational) = state==RISE && player_y<=CEIL_Y && time_gap<APEX_GAP.
- FALL:
  - Landing is checked first: any supporting floor → GROUND, floor_idx=winner, time_gap=0.
  - Otherwise move down 1 when due:
    - 1-79: when time_gap[2:0]==0
    - 80-159: when time_gap[1:0]==0
    - 160-239: when time_gap[0]==0
    - >=240: every tick
  - time_gap increments, saturating at 511.
  - If player_y+PLAYER_SIZE-1 > BOTTOM_Y after the move → DEAD.
- DEAD: all outputs frozen; left only via rst.
- Simultaneous jump_btn and floor loss in GROUND: the jump wins.
- jump_btn is ignored in RISE and FALL.

Optional Feature:
DOUBLE_JUMP_EN
- Defined:
  - One extra jump is allowed per airborne period. jump_btn=1 in FALL with the double-jump flag clear → RISE, time_gap=1, flag set.
  - The flag clears on landing and on rst.
  - Landing takes priority over a double jump in the same tick.
- Undefined: jump_btn is ignored outside GROUND; no flag register.

Test Plan:
- Reset with x0=150, y0=330, player_x=140 → player_y=310, on_floor=1, time_gap=0, floor_idx=0, hit_ceiling=0.
- jump_btn=1 for one tick, then 79 ticks → player_y=231, time_gap=80, state RISE.
- Continue rising with the default apex → player_y=231-40-20-10=161 at time_gap=320; next tick state FALL, time_gap=1.
- Override CEIL_Y=250, jump; after 60 move ticks player_y=250 → hit_ceiling=1; player_y stays 250 through time_gap 79; hit_ceiling drops on the FALL transition.
- In GROUND, ramp player_x to 205, past the floor-0 right edge of 200 → FALL next tick. With no floor below, the player falls until bottom >479 → dead=1; outputs then frozen for 100 more ticks.
- Falling player_x=290 onto floor 1 (x=300, y=460) with floor 3 disabled → lands at player_y=440, floor_idx=1, time_gap=0. With DOUBLE_JUMP_EN, jump in FALL → RISE once; a second press is ignored.

Source files
------------

// File: rtl/player_jump_ctrl.sv
// Player vertical-motion controller: owns player_y, the ground/rise/fall/dead
// state machine, floor landing and death detection, and produces the
// time_gap / hit_ceiling pair that drives floor scrolling.
// Optional build macro: DOUBLE_JUMP_EN (one extra jump per airborne period).
module player_jump_ctrl #(
  parameter int unsigned PLAYER_SIZE  = 20,
  parameter int unsigned FLOOR_HALF_W = 50,
  parameter int unsigned CEIL_Y       = 40,
  parameter int unsigned START_Y      = 310,
  parameter int unsigned BOTTOM_Y     = 479,
  parameter int unsigned APEX_GAP     = 320
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       jump_btn,
  input  logic [9:0] player_x,
  input  logic [9:0] floor_pos_x0,
  input  logic [9:0] floor_pos_x1,
  input  logic [9:0] floor_pos_x2,
  input  logic [9:0] floor_pos_x3,
  input  logic [9:0] floor_pos_y0,
  input  logic [9:0] floor_pos_y1,
  input  logic [9:0] floor_pos_y2,
  input  logic [9:0] floor_pos_y3,
  input  logic [3:0] enable,
  output logic [9:0] player_y,
  output logic [8:0] time_gap,
  output logic       hit_ceiling,
  output logic       on_floor,
  output logic       dead,
  output logic [1:0] floor_idx
);

  localparam logic [1:0] ST_GROUND = 2'd0;
  localparam logic [1:0] ST_RISE   = 2'd1;
  localparam logic [1:0] ST_FALL   = 2'd2;
  localparam logic [1:0] ST_DEAD   = 2'd3;

  localparam logic [10:0] SIZE11   = 11'(PLAYER_SIZE);
  localparam logic [10:0] HALF11   = 11'(FLOOR_HALF_W);
  localparam logic [10:0] BOTTOM11 = 11'(BOTTOM_Y);
  localparam logic [9:0]  SIZE10   = 10'(PLAYER_SIZE);
  localparam logic [9:0]  CEIL10   = 10'(CEIL_Y);
  localparam logic [9:0]  START10  = 10'(START_Y);
  localparam logic [8:0]  APEX9    = 9'(APEX_GAP);

  logic [1:0]  state;
  logic [9:0]  fx [4];
  logic [9:0]  fy [4];
  logic [10:0] left_edge [4];
  logic [10:0] right_edge [4];
  logic [3:0]  x_ovl;
  logic [3:0]  support;
  logic        land_any;
  logic [1:0]  land_idx;
  logic        rise_due;
  logic        fall_due;
  logic [10:0] fall_y;
  logic [8:0]  gap_inc;
`ifdef DOUBLE_JUMP_EN
  logic        dj_used;
`endif

  assign fx[0] = floor_pos_x0;
  assign fx[1] = floor_pos_x1;
  assign fx[2] = floor_pos_x2;
  assign fx[3] = floor_pos_x3;
  assign fy[0] = floor_pos_y0;
  assign fy[1] = floor_pos_y1;
  assign fy[2] = floor_pos_y2;
  assign fy[3] = floor_pos_y3;

  // Per-floor horizontal overlap and full landing contact, in 11-bit sums.
  // Ground keeps only the x/enable part so a scrolling floor drags the player.
  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      left_edge[i]  = ({1'b0, fx[i]} < HALF11) ? '0 : ({1'b0, fx[i]} - HALF11);
      right_edge[i] = {1'b0, fx[i]} + HALF11;
      x_ovl[i]      = enable[i]
                      && (({1'b0, player_x} + SIZE11 - 11'd1) >= left_edge[i])
                      && ({1'b0, player_x} <= right_edge[i]);
      support[i]    = x_ovl[i] && (({1'b0, player_y} + SIZE11) == {1'b0, fy[i]});
    end
  end

  // Lowest-index supporting floor wins.
  always_comb begin
    land_any = |support;
    land_idx = 2'd0;
    if (support[3]) land_idx = 2'd3;
    if (support[2]) land_idx = 2'd2;
    if (support[1]) land_idx = 2'd1;
    if (support[0]) land_idx = 2'd0;
  end

  // Rise slows and fall speeds up as time_gap grows.
  always_comb begin
    if (time_gap < 9'd80)       rise_due = 1'b1;
    else if (time_gap < 9'd160) rise_due = (time_gap[0] == 1'b0);
    else if (time_gap < 9'd240) rise_due = (time_gap[1:0] == 2'b00);
    else                        rise_due = (time_gap[2:0] == 3'b000);

    if (time_gap < 9'd80)       fall_due = (time_gap[2:0] == 3'b000);
    else if (time_gap < 9'd160) fall_due = (time_gap[1:0] == 2'b00);
    else if (time_gap < 9'd240) fall_due = (time_gap[0] == 1'b0);
    else                        fall_due = 1'b1;

    fall_y  = {1'b0, player_y} + (fall_due ? 11'd1 : 11'd0);
    gap_inc = (time_gap == 9'd511) ? time_gap : time_gap + 9'd1;
  end

  // Game-step state machine; everything holds when tick is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_GROUND;
      player_y  <= START10;
      time_gap  <= '0;
      floor_idx <= '0;
`ifdef DOUBLE_JUMP_EN
      dj_used   <= 1'b0;
`endif
    end else if (tick) begin
      case (state)
        ST_GROUND: begin
          if (jump_btn) begin
            state    <= ST_RISE;
            time_gap <= 9'd1;
          end else if (!x_ovl[floor_idx]) begin
            state    <= ST_FALL;
            time_gap <= 9'd1;
          end else begin
            time_gap <= '0;
            player_y <= fy[floor_idx] - SIZE10;
          end
        end
        ST_RISE: begin
          if (time_gap >= APEX9) begin
            state    <= ST_FALL;
            time_gap <= 9'd1;
          end else begin
            if (rise_due && (player_y > CEIL10)) player_y <= player_y - 10'd1;
            time_gap <= time_gap + 9'd1;
          end
        end
        ST_FALL: begin
          if (land_any) begin
            state     <= ST_GROUND;
            floor_idx <= land_idx;
            time_gap  <= '0;
`ifdef DOUBLE_JUMP_EN
            dj_used   <= 1'b0;
          end else if (jump_btn && !dj_used) begin
            state    <= ST_RISE;
            time_gap <= 9'd1;
            dj_used  <= 1'b1;
`endif
          end else begin
            player_y <= fall_y[9:0];
            time_gap <= gap_inc;
            if ((fall_y + SIZE11 - 11'd1) > BOTTOM11) state <= ST_DEAD;
          end
        end
        default: begin
          state <= ST_DEAD;
        end
      endcase
    end
  end

  assign hit_ceiling = (state == ST_RISE) && (player_y <= CEIL10) && (time_gap < APEX9);
  assign on_floor    = (state == ST_GROUND);
  assign dead        = (state == ST_DEAD);

endmodule

// File: tb/tb_player_jump_ctrl.sv
// Directed bench for player_jump_ctrl: rise profile, apex, fall/landing,
// ceiling hold with a lowered CEIL_Y, floor loss, death and freeze.
module tb_player_jump_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       jump_btn;
  logic [9:0] player_x;
  logic [9:0] x0, x1, x2, x3, y0, y1, y2, y3;
  logic [3:0] enable;

  logic [9:0] py_a, py_b;
  logic [8:0] tg_a, tg_b;
  logic       hc_a, hc_b, of_a, of_b, dd_a, dd_b;
  logic [1:0] fi_a, fi_b;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  player_jump_ctrl dut_a (
    .clk(clk), .rst(rst), .tick(tick), .jump_btn(jump_btn), .player_x(player_x),
    .floor_pos_x0(x0), .floor_pos_x1(x1), .floor_pos_x2(x2), .floor_pos_x3(x3),
    .floor_pos_y0(y0), .floor_pos_y1(y1), .floor_pos_y2(y2), .floor_pos_y3(y3),
    .enable(enable), .player_y(py_a), .time_gap(tg_a), .hit_ceiling(hc_a),
    .on_floor(of_a), .dead(dd_a), .floor_idx(fi_a)
  );

  player_jump_ctrl #(.CEIL_Y(250)) dut_b (
    .clk(clk), .rst(rst), .tick(tick), .jump_btn(jump_btn), .player_x(player_x),
    .floor_pos_x0(x0), .floor_pos_x1(x1), .floor_pos_x2(x2), .floor_pos_x3(x3),
    .floor_pos_y0(y0), .floor_pos_y1(y1), .floor_pos_y2(y2), .floor_pos_y3(y3),
    .enable(enable), .player_y(py_b), .time_gap(tg_b), .hit_ceiling(hc_b),
    .on_floor(of_b), .dead(dd_b), .floor_idx(fi_b)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; tick = 1'b1; jump_btn = 1'b0; player_x = 10'd140;
    x0 = 10'd150; y0 = 10'd330;
    x1 = 10'd300; y1 = 10'd460;
    x2 = 10'd800; y2 = 10'd100;
    x3 = 10'd300; y3 = 10'd400;   // would catch the player first if enabled
    enable = 4'b0111;
    step(2);
    check("rst_y", py_a, 310);
    check("rst_on_floor", of_a, 1);
    check("rst_tg", tg_a, 0);
    check("rst_idx", fi_a, 0);
    check("rst_hc", hc_a, 0);
    check("rst_dead", dd_a, 0);

    // tick low: jump request must not act
    rst = 1'b0; tick = 1'b0; jump_btn = 1'b1;
    step(3);
    check("notick_on_floor", of_a, 1);
    check("notick_tg", tg_a, 0);

    // jump, then 79 full-speed rising ticks
    tick = 1'b1;
    step(1);
    check("jump_on_floor", of_a, 0);
    check("jump_tg", tg_a, 1);
    check("jump_y", py_a, 310);
    jump_btn = 1'b0;
    step(79);
    check("rise79_y", py_a, 231);
    check("rise79_tg", tg_a, 80);
    check("rise79_hc", hc_a, 0);
    step(240);
    check("apex_y", py_a, 161);
    check("apex_tg", tg_a, 320);
    step(1);
    check("fall_tg", tg_a, 1);
    check("fall_y", py_a, 161);
    step(79);
    check("fall80_y", py_a, 170);
    check("fall80_tg", tg_a, 80);

    // land back on floor 0
    for (int n = 0; n < 1000 && !of_a; n++) step(1);
    check("land0_on_floor", of_a, 1);
    check("land0_y", py_a, 310);
    check("land0_idx", fi_a, 0);
    check("land0_tg", tg_a, 0);

    // ground follows a scrolling floor
    y0 = 10'd320;
    step(1);
    check("track_y", py_a, 300);
    y0 = 10'd330;
    step(1);
    check("track_back_y", py_a, 310);

    // right-edge boundary of floor 0 (edge at 200)
    player_x = 10'd200;
    step(1);
    check("edge200_on_floor", of_a, 1);
    player_x = 10'd201;
    step(1);
    check("edge201_on_floor", of_a, 0);
    check("edge201_tg", tg_a, 1);
    player_x = 10'd205;
    for (int n = 0; n < 1000 && !dd_a; n++) step(1);
    check("dead", dd_a, 1);
    check("dead_y", py_a, 461);
    check("dead_tg", tg_a, 322);
    jump_btn = 1'b1; y0 = 10'd200;
    step(100);
    check("frozen_y", py_a, 461);
    check("frozen_tg", tg_a, 322);
    check("frozen_dead", dd_a, 1);
    check("frozen_on_floor", of_a, 0);
    jump_btn = 1'b0; y0 = 10'd330;

    // fall onto floor 1 past disabled floor 3
    rst = 1'b1; player_x = 10'd140;
    step(2);
    rst = 1'b0; player_x = 10'd290;
    step(1);
    check("loss_tg", tg_a, 1);
    for (int n = 0; n < 1000 && !of_a; n++) step(1);
    check("land1_on_floor", of_a, 1);
    check("land1_y", py_a, 440);
    check("land1_idx", fi_a, 1);
    check("land1_tg", tg_a, 0);

    // jump beats simultaneous floor loss
    player_x = 10'd400; jump_btn = 1'b1;
    step(1);
    check("jwin_on_floor", of_a, 0);
    check("jwin_tg", tg_a, 1);
    check("jwin_y", py_a, 440);
    jump_btn = 1'b0;
    step(1);
    check("jwin_rise_y", py_a, 439);
    check("jwin_rise_tg", tg_a, 2);

    // lowered ceiling on dut_b
    rst = 1'b1; player_x = 10'd140;
    step(2);
    rst = 1'b0; jump_btn = 1'b1;
    step(1);
    jump_btn = 1'b0;
    step(60);
    check("ceil_y", py_b, 250);
    check("ceil_tg", tg_b, 61);
    check("ceil_hc", hc_b, 1);
    check("ceil_hc_a", hc_a, 0);
    step(18);
    check("ceil79_y", py_b, 250);
    check("ceil79_tg", tg_b, 79);
    check("ceil79_hc", hc_b, 1);
    step(240);
    check("ceil319_hc", hc_b, 1);
    check("ceil319_y", py_b, 250);
    step(1);
    check("ceil320_hc", hc_b, 0);
    step(1);
    check("ceil_fall_tg", tg_b, 1);
    check("ceil_fall_hc", hc_b, 0);
    check("ceil_fall_on_floor", of_b, 0);

`ifdef DOUBLE_JUMP_EN
    rst = 1'b1; player_x = 10'd140;
    step(2);
    rst = 1'b0; player_x = 10'd290;
    step(1);
    jump_btn = 1'b1;
    step(1);
    check("dj_tg", tg_a, 1);
    check("dj_y", py_a, 310);
    jump_btn = 1'b0;
    step(1);
    check("dj_rise_y", py_a, 309);
    step(318);
    check("dj_apex_y", py_a, 161);
    step(1);
    check("dj_fall_tg", tg_a, 1);
    jump_btn = 1'b1;
    step(1);
    check("dj_second_tg", tg_a, 2);
    check("dj_second_y", py_a, 161);
    jump_btn = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
